tb_obi_mem_stall: RTL and testbench
===================================

Name: tb_obi_mem_stall

Overview:
Parametrised multi-port OBI memory model for the core testbench subsystem. It generalises the fixed instr/data RAM to NUM_PORTS independent OBI ports, with configurable response latency, an outstanding-transaction limit, and pseudo-random grant stall injection for bus-protocol stress. It also hosts the memory-mapped pass/fail/exit pseudo-peripherals.

Parameters:
NUM_PORTS, 2, number of OBI ports (port 0 = instr, port 1 = data by convention).
ADDR_WIDTH, 20, byte address width of the backing RAM (2^ADDR_WIDTH bytes).
RESP_LATENCY, 1, cycles from grant edge to rvalid (legal range 1..8).
MAX_OUTSTANDING, 2, per-port limit on granted-but-not-responded transactions (legal range 1..RESP_LATENCY+1).
STALL_EN, 0, 1 enables LFSR grant stalls.
LFSR_SEED, 16'hACE1, stall LFSR seed (must be nonzero).
TEST_ADDR, 32'h2000_0000, pass/fail register address.
EXIT_ADDR, 32'h2000_0004, exit register address.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NUM_PORTS  per-port request
addr_i  in  NUM_PORTS*32  per-port byte address; word-aligned, addr[1:0] ignored
we_i  in  NUM_PORTS  1 = write
be_i  in  NUM_PORTS*4  byte enables
wdata_i  in  NUM_PORTS*32  write data
gnt_o  out  NUM_PORTS  grant (combinational)
rvalid_o  out  NUM_PORTS  response valid
rdata_o  out  NUM_PORTS*32  read data, valid with rvalid_o
tests_passed_o  out  1  one-cycle pulse
tests_failed_o  out  1  one-cycle pulse
exit_valid_o  out  1  one-cycle pulse
exit_value_o  out  32  value accompanying exit_valid_o

Behaviour:
- Reset: all outputs 0; outstanding counters 0; response pipelines cleared. Per-port LFSR = LFSR_SEED ^ port index, forced nonzero. RAM contents are not reset. Reset mid-transaction drops in-flight responses with no rvalid.
- Per-port LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every cycle. stall[p] = STALL_EN & lfsr[p][0].
- Grant: gnt_o[p] = req_i[p] & ~stall[p] & ((cnt[p] - rvalid_o[p]) < MAX_OUTSTANDING).
- A transaction is accepted on the clock edge where req & gnt are both high. cnt increments on accept and decrements on rvalid; both in the same cycle leaves cnt unchanged.
- RAM access happens at the accept edge:
  - Write: updates the enabled bytes only.
  - Read: samples the word, pre-write.
- Same-cycle conflicts:
  - Two ports writing the same word: per byte, the lowest-index port wins.
  - Read and write to the same word in the same cycle: the read returns old data.
- Response: the accepted read data (0 for writes) enters a per-port fixed-latency shift pipeline. rvalid_o[p] rises exactly RESP_LATENCY cycles after the accept edge. Responses are in order. rdata_o is 0 when rvalid_o is low.
- Address decode, on the full 32-bit address:
  - TEST_ADDR write: wdata==32'd123456789 pulses tests_passed_o; wdata==32'd1 pulses tests_failed_o; other values have no effect.
  - EXIT_ADDR write: pulses exit_valid_o with exit_value_o=wdata, both set the cycle after accept. exit_value_o holds its value until the next exit write.
  - Peripheral pulses from multiple ports in one cycle: the lowest-index port wins.
  - addr < 2^ADDR_WIDTH: RAM access.
  - Anything else: write dropped, read returns 32'hDEAD_BEEF.
  - Every accepted transaction gets exactly one rvalid, whatever its decode.
- Ports are fully independent; there is no cross-port arbitration stall.

Test Plan:
- STALL_EN=0, RESP_LATENCY=1: port1 writes 0xCAFEF00D to 0x100 with be=4'b1111, then port0 reads 0x100 -> port0 rvalid 1 cycle after its grant, rdata=0xCAFEF00D.
- Byte enables: word 0x200 preset to 0x11223344; write 0xAABBCCDD with be=4'b0101; then read -> 0x11BB33DD.
- MAX_OUTSTANDING=1, RESP_LATENCY=3, req held high continuously -> grants on cycles 0, 3, 6; rvalid on cycles 3, 6, 9; cnt never exceeds 1.
- Same cycle: port0 and port1 both write 0x300, port0 0x00000001 and port1 0xFFFFFFFF -> later read returns 0x00000001.
- Write 123456789 to 0x2000_0000 -> tests_passed_o pulses one cycle. Write 0x2A to 0x2000_0004 -> exit_valid_o=1 for one cycle, exit_value_o=0x2A. Read 0x3000_0000 -> 0xDEADBEEF.
- STALL_EN=1, 1000 random requests, with rst_ni asserted at cycle 500 -> gnt never high when lfsr[0]=1. Every accept before reset gets exactly one rvalid unless dropped by reset. After reset, cnt=0 and rvalid=0.

Source files
------------

// File: rtl/tb_obi_mem_stall.sv
// Multi-port OBI memory model with fixed response latency, outstanding limit,
// LFSR grant stalls and pass/fail/exit pseudo-peripherals.
module tb_obi_mem_stall #(
    parameter int          NUM_PORTS       = 2,
    parameter int          ADDR_WIDTH      = 20,
    parameter int          RESP_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter bit          STALL_EN        = 1'b0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter logic [31:0] TEST_ADDR       = 32'h2000_0000,
    parameter logic [31:0] EXIT_ADDR       = 32'h2000_0004
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_PORTS-1:0]    req_i,
    input  logic [NUM_PORTS*32-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [NUM_PORTS*4-1:0]  be_i,
    input  logic [NUM_PORTS*32-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]    gnt_o,
    output logic [NUM_PORTS-1:0]    rvalid_o,
    output logic [NUM_PORTS*32-1:0] rdata_o,
    output logic                    tests_passed_o,
    output logic                    tests_failed_o,
    output logic                    exit_valid_o,
    output logic [31:0]             exit_value_o
);

    localparam int          NW       = 2 ** (ADDR_WIDTH - 2);
    localparam int          CW       = 4;
    localparam logic [31:0] PASS_VAL = 32'd123456789;
    localparam logic [31:0] FAIL_VAL = 32'd1;
    localparam logic [32:0] RAM_LIM  = 33'd1 << ADDR_WIDTH;

    logic [31:0]             mem   [NW];
    logic [15:0]             lfsr  [NUM_PORTS];
    logic [CW-1:0]           cnt   [NUM_PORTS];
    logic [RESP_LATENCY-1:0] pv    [NUM_PORTS];
    logic [31:0]             pd    [NUM_PORTS][RESP_LATENCY];

    logic [31:0]           addr  [NUM_PORTS];
    logic [31:0]           wdata [NUM_PORTS];
    logic [3:0]            be    [NUM_PORTS];
    logic [31:0]           rsp   [NUM_PORTS];
    logic [ADDR_WIDTH-3:0] widx  [NUM_PORTS];

    logic [NUM_PORTS-1:0] acc;
    logic [NUM_PORTS-1:0] stall;
    logic [NUM_PORTS-1:0] is_test;
    logic [NUM_PORTS-1:0] is_exit;
    logic [NUM_PORTS-1:0] ram_ok;

    logic        t_hit;
    logic        e_hit;
    logic [31:0] t_val;
    logic [31:0] e_val;
    logic        unused_lsb;

    function automatic logic [15:0] seed_of(input int p);
        logic [15:0] s;
        s = LFSR_SEED ^ 16'(p);
        return (s == 16'h0) ? 16'h1 : s;
    endfunction

    // Galois form of x^16+x^14+x^13+x^11
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign addr[g]  = addr_i[g*32 +: 32];
        assign wdata[g] = wdata_i[g*32 +: 32];
        assign be[g]    = be_i[g*4 +: 4];
        assign widx[g]  = addr[g][ADDR_WIDTH-1:2];
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rvalid_o[p] = pv[p][RESP_LATENCY-1];
            if (pv[p][RESP_LATENCY-1])
                rdata_o[p*32 +: 32] = pd[p][RESP_LATENCY-1];
        end
    end

    always_comb begin
        gnt_o      = '0;
        acc        = '0;
        stall      = '0;
        is_test    = '0;
        is_exit    = '0;
        ram_ok     = '0;
        unused_lsb = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp[p]     = '0;
            stall[p]   = STALL_EN & lfsr[p][0];
            gnt_o[p]   = req_i[p] & ~stall[p]
                       & ((cnt[p] - CW'(rvalid_o[p]))
                          < CW'(MAX_OUTSTANDING));
            acc[p]     = req_i[p] & gnt_o[p];
            is_test[p] = (addr[p][31:2] == TEST_ADDR[31:2]);
            is_exit[p] = (addr[p][31:2] == EXIT_ADDR[31:2]);
            ram_ok[p]  = ({1'b0, addr[p]} < RAM_LIM)
                       & ~is_test[p] & ~is_exit[p];
            if (!we_i[p])
                rsp[p] = ram_ok[p] ? mem[widx[p]] : 32'hDEAD_BEEF;
            unused_lsb = unused_lsb ^ (^addr[p][1:0]);
        end
    end

    // Descending scan so the lowest-index port has the final say
    always_comb begin
        t_hit = 1'b0;
        t_val = '0;
        e_hit = 1'b0;
        e_val = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (acc[p] && we_i[p] && is_test[p]) begin
                t_hit = 1'b1;
                t_val = wdata[p];
            end
            if (acc[p] && we_i[p] && is_exit[p]) begin
                e_hit = 1'b1;
                e_val = wdata[p];
            end
        end
    end

    // Last NBA wins, so writing high ports first gives low ports priority
    always_ff @(posedge clk_i) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (acc[p] && we_i[p] && ram_ok[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[p][b])
                        mem[widx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                lfsr[p] <= seed_of(p);
                cnt[p]  <= '0;
                pv[p]   <= '0;
                for (int s = 0; s < RESP_LATENCY; s++)
                    pd[p][s] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                lfsr[p]  <= lfsr_next(lfsr[p]);
                cnt[p]   <= cnt[p] + CW'(acc[p]) - CW'(rvalid_o[p]);
                pv[p][0] <= acc[p];
                pd[p][0] <= acc[p] ? rsp[p] : 32'h0;
                for (int s = 1; s < RESP_LATENCY; s++) begin
                    pv[p][s] <= pv[p][s-1];
                    pd[p][s] <= pd[p][s-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else begin
            tests_passed_o <= t_hit && (t_val == PASS_VAL);
            tests_failed_o <= t_hit && (t_val == FAIL_VAL);
            exit_valid_o   <= e_hit;
            if (e_hit)
                exit_value_o <= e_val;
        end
    end

endmodule

// File: tb/tb_tb_obi_mem_stall.sv
// Directed and random scoreboard bench for the OBI memory model:
// default, long-latency/single-outstanding and stalled configurations.
module tb_tb_obi_mem_stall;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic c_rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [1:0]  a_req = '0, a_we = '0, a_gnt, a_rvalid;
    logic [63:0] a_addr = '0, a_wdata = '0, a_rdata;
    logic [7:0]  a_be = '0;
    logic        a_pass, a_fail, a_exv;
    logic [31:0] a_exval;

    logic [1:0]  b_req = '0, b_we = '0, b_gnt, b_rvalid;
    logic [63:0] b_addr = '0, b_wdata = '0, b_rdata;
    logic [7:0]  b_be = '0;
    logic        b_pass, b_fail, b_exv;
    logic [31:0] b_exval;

    logic [1:0]  c_req = '0, c_we = '0, c_gnt, c_rvalid;
    logic [63:0] c_addr = '0, c_wdata = '0, c_rdata;
    logic [7:0]  c_be = '0;
    logic        c_pass, c_fail, c_exv;
    logic [31:0] c_exval;

    tb_obi_mem_stall #(.ADDR_WIDTH(16)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .addr_i(a_addr),
        .we_i(a_we), .be_i(a_be), .wdata_i(a_wdata), .gnt_o(a_gnt),
        .rvalid_o(a_rvalid), .rdata_o(a_rdata), .tests_passed_o(a_pass),
        .tests_failed_o(a_fail), .exit_valid_o(a_exv),
        .exit_value_o(a_exval));

    tb_obi_mem_stall #(.ADDR_WIDTH(16), .RESP_LATENCY(3),
                       .MAX_OUTSTANDING(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .addr_i(b_addr),
        .we_i(b_we), .be_i(b_be), .wdata_i(b_wdata), .gnt_o(b_gnt),
        .rvalid_o(b_rvalid), .rdata_o(b_rdata), .tests_passed_o(b_pass),
        .tests_failed_o(b_fail), .exit_valid_o(b_exv),
        .exit_value_o(b_exval));

    tb_obi_mem_stall #(.ADDR_WIDTH(16), .RESP_LATENCY(2),
                       .MAX_OUTSTANDING(2), .STALL_EN(1'b1)) u_c (
        .clk_i(clk), .rst_ni(c_rst_n), .req_i(c_req), .addr_i(c_addr),
        .we_i(c_we), .be_i(c_be), .wdata_i(c_wdata), .gnt_o(c_gnt),
        .rvalid_o(c_rvalid), .rdata_o(c_rdata), .tests_passed_o(c_pass),
        .tests_failed_o(c_fail), .exit_valid_o(c_exv),
        .exit_value_o(c_exval));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the default instance
    logic [31:0] qa0[$];
    logic [31:0] qa1[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rvalid[0]) begin
                chk("a0_has_pending", 32'(qa0.size() > 0), 32'd1);
                if (qa0.size() > 0) chk("a0_rdata", a_rdata[31:0], qa0.pop_front());
            end else begin
                chk("a0_rdata_idle", a_rdata[31:0], 32'h0);
            end
            if (a_rvalid[1]) begin
                chk("a1_has_pending", 32'(qa1.size() > 0), 32'd1);
                if (qa1.size() > 0) chk("a1_rdata", a_rdata[63:32], qa1.pop_front());
            end else begin
                chk("a1_rdata_idle", a_rdata[63:32], 32'h0);
            end
        end
    end

    task automatic op_a(input int p, input logic w, input logic [31:0] ad,
                        input logic [3:0] b, input logic [31:0] wd,
                        input logic [31:0] exp);
        int n = 0;
        a_req[p] = 1'b1;
        a_we[p] = w;
        a_addr[p*32 +: 32] = ad;
        a_be[p*4 +: 4] = b;
        a_wdata[p*32 +: 32] = wd;
        @(negedge clk);
        while (a_gnt[p] !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("a_gnt", 32'(a_gnt[p]), 32'd1);
        @(posedge clk);
        if (p == 0) qa0.push_back(exp);
        else qa1.push_back(exp);
        #1 a_req[p] = 1'b0;
    endtask

    task automatic op_a2(input logic w0, input logic [31:0] ad0,
                         input logic [31:0] wd0, input logic [31:0] e0,
                         input logic w1, input logic [31:0] ad1,
                         input logic [31:0] wd1, input logic [31:0] e1);
        int n = 0;
        a_req = 2'b11;
        a_we = {w1, w0};
        a_addr = {ad1, ad0};
        a_be = 8'hFF;
        a_wdata = {wd1, wd0};
        @(negedge clk);
        while (a_gnt !== 2'b11 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("a_gnt_both", 32'(a_gnt), 32'd3);
        @(posedge clk);
        qa0.push_back(e0);
        qa1.push_back(e1);
        #1 a_req = 2'b00;
    endtask

    task automatic op_b(input logic w, input logic [31:0] ad,
                        input logic [31:0] wd);
        int n = 0;
        b_req[0] = 1'b1;
        b_we[0] = w;
        b_addr[31:0] = ad;
        b_be[3:0] = 4'hF;
        b_wdata[31:0] = wd;
        @(negedge clk);
        while (b_gnt[0] !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("b_gnt_op", 32'(b_gnt[0]), 32'd1);
        @(posedge clk);
        #1 b_req[0] = 1'b0;
    endtask

    // Reference stall LFSRs for the stalled instance
    logic [15:0] mlfsr [2];
    always @(posedge clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            mlfsr[0] <= 16'hACE1;
            mlfsr[1] <= 16'hACE0;
        end else begin
            for (int p = 0; p < 2; p++)
                mlfsr[p] <= {1'b0, mlfsr[p][15:1]}
                          ^ (mlfsr[p][0] ? 16'hB400 : 16'h0000);
        end
    end

    typedef struct {
        int          port;
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        cq[$];
    logic [31:0] shadow [8];
    bit          known  [8];
    int          mcnt   [2];
    int          wi     [2];
    bit          oob    [2];
    logic [1:0]  eg, erv, acc;
    logic [31:0] rd     [2];
    int          bcnt;
    int          idx;

    initial begin
        for (int i = 0; i < 8; i++) known[i] = 1'b0;
        mcnt[0] = 0;
        mcnt[1] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_gnt", 32'(a_gnt), 32'd0);
        chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_a_rdata", a_rdata[31:0] | a_rdata[63:32], 32'h0);
        chk("rst_a_pass", 32'(a_pass), 32'd0);
        chk("rst_a_fail", 32'(a_fail), 32'd0);
        chk("rst_a_exv", 32'(a_exv), 32'd0);
        chk("rst_a_exval", a_exval, 32'h0);
        chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        step();
        rst_n = 1'b1;

        // Write then read back, single-cycle latency
        op_a(1, 1'b1, 32'h100, 4'hF, 32'hCAFE_F00D, 32'h0);
        op_a(0, 1'b0, 32'h100, 4'hF, 32'h0, 32'hCAFE_F00D);
        @(negedge clk);
        chk("a_lat1_rvalid", 32'(a_rvalid[0]), 32'd1);
        step();

        // Byte enables
        op_a(0, 1'b1, 32'h200, 4'hF, 32'h1122_3344, 32'h0);
        op_a(0, 1'b1, 32'h200, 4'b0101, 32'hAABB_CCDD, 32'h0);
        op_a(1, 1'b0, 32'h202, 4'hF, 32'h0, 32'h11BB_33DD);

        // Same-word write conflict and read-vs-write conflict
        op_a2(1'b1, 32'h300, 32'h0000_0001, 32'h0,
              1'b1, 32'h300, 32'hFFFF_FFFF, 32'h0);
        op_a(1, 1'b0, 32'h300, 4'hF, 32'h0, 32'h0000_0001);
        op_a2(1'b0, 32'h100, 32'h0, 32'hCAFE_F00D,
              1'b1, 32'h100, 32'h1234_5678, 32'h0);
        op_a(0, 1'b0, 32'h100, 4'hF, 32'h0, 32'h1234_5678);

        // Out of range: write dropped (no aliasing), read returns marker
        op_a(1, 1'b1, 32'h3001_0100, 4'hF, 32'hDEAD_DEAD, 32'h0);
        op_a(0, 1'b0, 32'h100, 4'hF, 32'h0, 32'h1234_5678);
        op_a(0, 1'b0, 32'h3000_0000, 4'hF, 32'h0, 32'hDEAD_BEEF);

        // Pseudo-peripherals
        op_a(1, 1'b1, 32'h2000_0000, 4'hF, 32'd123456789, 32'h0);
        @(negedge clk);
        chk("pass_pulse", 32'(a_pass), 32'd1);
        chk("pass_nofail", 32'(a_fail), 32'd0);
        @(negedge clk);
        chk("pass_end", 32'(a_pass), 32'd0);
        step();
        op_a(0, 1'b1, 32'h2000_0000, 4'hF, 32'd1, 32'h0);
        @(negedge clk);
        chk("fail_pulse", 32'(a_fail), 32'd1);
        chk("fail_nopass", 32'(a_pass), 32'd0);
        @(negedge clk);
        chk("fail_end", 32'(a_fail), 32'd0);
        step();
        op_a(0, 1'b1, 32'h2000_0000, 4'hF, 32'd5, 32'h0);
        @(negedge clk);
        chk("other_val", 32'({a_pass, a_fail}), 32'd0);
        step();
        op_a(1, 1'b1, 32'h2000_0004, 4'hF, 32'h2A, 32'h0);
        @(negedge clk);
        chk("exit_valid", 32'(a_exv), 32'd1);
        chk("exit_value", a_exval, 32'h2A);
        @(negedge clk);
        chk("exit_valid_end", 32'(a_exv), 32'd0);
        chk("exit_value_hold", a_exval, 32'h2A);
        step();
        op_a2(1'b1, 32'h2000_0004, 32'h11, 32'h0,
              1'b1, 32'h2000_0004, 32'h22, 32'h0);
        @(negedge clk);
        chk("exit_prio_valid", 32'(a_exv), 32'd1);
        chk("exit_prio_value", a_exval, 32'h11);
        repeat (3) step();
        chk("a_drain", 32'(qa0.size() + qa1.size()), 32'd0);

        // Long latency, one outstanding, request held high
        b_req[0] = 1'b1;
        b_we[0] = 1'b1;
        b_addr[31:0] = 32'h10;
        b_be[3:0] = 4'hF;
        b_wdata[31:0] = 32'h0;
        bcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("b_gnt", 32'(b_gnt[0]), 32'(c % 3 == 0));
            chk("b_rvalid", 32'(b_rvalid[0]), 32'(c > 0 && c % 3 == 0));
            chk("b_rdata_w", b_rdata[31:0], 32'h0);
            bcnt = bcnt + int'(b_gnt[0]) - int'(b_rvalid[0]);
            chk("b_cnt_max", 32'(bcnt <= 1), 32'd1);
        end
        step();
        b_req[0] = 1'b0;
        @(negedge clk);
        chk("b_last_rvalid", 32'(b_rvalid[0]), 32'd1);
        chk("b_last_gnt", 32'(b_gnt[0]), 32'd0);
        @(negedge clk);
        chk("b_idle", 32'(b_rvalid), 32'd0);
        step();
        op_b(1'b1, 32'h40, 32'h5A5A_1234);
        op_b(1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk("b_rd_lat1", 32'(b_rvalid[0]), 32'd0);
        @(negedge clk);
        chk("b_rd_lat2", 32'(b_rvalid[0]), 32'd0);
        @(negedge clk);
        chk("b_rd_lat3", 32'(b_rvalid[0]), 32'd1);
        chk("b_rd_data", b_rdata[31:0], 32'h5A5A_1234);
        chk("b_port1_idle", 32'({b_gnt[1], b_rvalid[1]}), 32'd0);
        step();

        // Stalled instance: random traffic with a reset in the middle
        c_rst_n = 1'b1;
        for (int k = 0; k < 1010; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (k < 1000 && k != 501 && k != 502) begin
                    c_req[p] = 1'($urandom_range(0, 1));
                    wi[p] = int'($urandom_range(0, 7));
                    oob[p] = ($urandom_range(0, 7) == 0);
                    c_we[p] = 1'($urandom_range(0, 1));
                    c_be[p*4 +: 4] = 4'($urandom_range(1, 15));
                    if (!oob[p] && !known[wi[p]]) begin
                        c_we[p] = 1'b1;
                        c_be[p*4 +: 4] = 4'hF;
                    end
                    c_addr[p*32 +: 32] = (oob[p] ? 32'h3000_0000 : 32'h80)
                                       + 32'(wi[p] * 4);
                    c_wdata[p*32 +: 32] = $urandom;
                end else begin
                    c_req[p] = 1'b0;
                end
            end
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                idx = -1;
                foreach (cq[i]) if (idx < 0 && cq[i].port == p) idx = i;
                erv[p] = (idx >= 0) && (cq[idx].due == k);
                chk("c_rvalid", 32'(c_rvalid[p]), 32'(erv[p]));
                if (erv[p]) begin
                    chk("c_rdata", c_rdata[p*32 +: 32], cq[idx].data);
                    cq.delete(idx);
                end else begin
                    chk("c_rdata_idle", c_rdata[p*32 +: 32], 32'h0);
                end
                eg[p] = c_req[p] & ~mlfsr[p][0]
                      & ((mcnt[p] - int'(erv[p])) < 2);
                chk("c_gnt", 32'(c_gnt[p]), 32'(eg[p]));
                if (mlfsr[p][0]) chk("c_stall_gnt", 32'(c_gnt[p]), 32'd0);
                if (k == 501 || k == 502)
                    chk("c_rst_rvalid", 32'(c_rvalid[p]), 32'd0);
            end
            for (int p = 0; p < 2; p++) begin
                acc[p] = eg[p] & c_rst_n;
                mcnt[p] = mcnt[p] + int'(acc[p]) - int'(erv[p]);
                rd[p] = c_we[p] ? 32'h0
                      : (oob[p] ? 32'hDEAD_BEEF : shadow[wi[p]]);
            end
            for (int p = 1; p >= 0; p--) begin
                if (acc[p] && c_we[p] && !oob[p]) begin
                    for (int b = 0; b < 4; b++)
                        if (c_be[p*4 + b])
                            shadow[wi[p]][8*b +: 8] = c_wdata[p*32 + 8*b +: 8];
                    known[wi[p]] = 1'b1;
                end
            end
            for (int p = 0; p < 2; p++)
                if (acc[p]) cq.push_back('{p, k + 2, rd[p]});
            step();
            if (k == 500) begin
                c_rst_n = 1'b0;
                cq.delete();
                mcnt[0] = 0;
                mcnt[1] = 0;
            end
            if (k == 502) c_rst_n = 1'b1;
        end
        chk("c_drain", 32'(cq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
